// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
//
// Purpose:
//   Memory-side initiator for the RV32I core. Arbitrates between the
//   instruction-fetch channel and the load/store channel. Checks alignment
//   and funct3 legality, then issues one access at a time to the
//   single-ported memory block. Each request completes in three cycles:
//     IDLE  : handshake
//     ISSUE : memory captures the access
//     RESP  : one-cycle response strobe on the granted channel
//
// Ports:
//   clk, reset                 system clock, synchronous active-high reset
//   if_valid/if_ready/if_addr  fetch request channel
//   if_rsp_valid/_data/_err    fetch response (one-cycle strobe)
//   d_valid/d_ready/d_write/
//   d_funct3/d_addr/d_wdata    load/store request channel
//   d_rsp_valid/_rdata/_err    data response (one-cycle strobe)
//   mem_write, mem_funct3,
//   mem_write_address/_data,
//   mem_read_address           drive the memory block
//   mem_read_data              registered read data from memory
// ---------------------------------------------------------------------------
module mem_access_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic        if_valid,
   output logic        if_ready,
   input  logic [31:0] if_addr,
   output logic        if_rsp_valid,
   output logic [31:0] if_rsp_data,
   output logic        if_rsp_err,
   input  logic        d_valid,
   output logic        d_ready,
   input  logic        d_write,
   input  logic [2:0]  d_funct3,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_rsp_valid,
   output logic [31:0] d_rsp_rdata,
   output logic        d_rsp_err,
   output logic        mem_write,
   output logic [2:0]  mem_funct3,
   output logic [31:0] mem_write_address,
   output logic [31:0] mem_write_data,
   output logic [31:0] mem_read_address,
   input  logic [31:0] mem_read_data
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_RESP  = 2'd2
   } state_t;

   localparam logic       CH_FETCH = 1'b0;
   localparam logic       CH_DATA  = 1'b1;
   localparam logic [2:0] F3_WORD  = 3'b010;

   state_t      r_state;
   state_t      w_next_state;
   logic        r_last_grant;
   logic        r_chan;
   logic        r_write;
   logic        r_err;
   logic [2:0]  r_funct3;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;

   logic        w_idle;
   logic        w_grant_f;
   logic        w_grant_d;
   logic        w_hs;
   logic [31:0] w_rsp_data;

   // Access legality. Loads accept 000/001/010/100/101, stores only
   // 000/001/010; halfwords need addr[0]==0 and words addr[1:0]==0.
   function automatic logic f_access_err(input logic       is_fetch,
                                         input logic       is_write,
                                         input logic [2:0] f3,
                                         input logic [1:0] a);
      logic err;
      if (is_fetch) begin
         err = (a != 2'b00);
      end else begin
         case (f3)
            3'b000:         err = 1'b0;
            3'b001:         err = a[0];
            3'b010:         err = (a != 2'b00);
            3'b100, 3'b101: err = is_write | (f3[0] & a[0]);
            default:        err = 1'b1;
         endcase
      end
      return err;
   endfunction

   // Arbitration: a channel is ready in IDLE unless the other channel is
   // also requesting and wins the round-robin tie. The two readies are
   // therefore never both high while both valids are high.
   assign w_idle    = (r_state == S_IDLE) && !reset;
   assign if_ready  = w_idle && (!d_valid  || (r_last_grant == CH_DATA));
   assign d_ready   = w_idle && (!if_valid || (r_last_grant == CH_FETCH));
   assign w_grant_f = if_valid && if_ready;
   assign w_grant_d = d_valid && d_ready;
   assign w_hs      = w_grant_f || w_grant_d;

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:  if (w_hs) w_next_state = S_ISSUE;
         S_ISSUE: w_next_state = S_RESP;
         S_RESP:  w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   // Request latch. Fetches are forced to word reads. Write data is kept
   // across fetches because it is never written for them.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_last_grant <= CH_FETCH;
         r_chan       <= CH_FETCH;
         r_write      <= 1'b0;
         r_err        <= 1'b0;
         r_funct3     <= F3_WORD;
         r_addr       <= 32'd0;
         r_wdata      <= 32'd0;
      end else if (w_grant_f) begin
         r_last_grant <= CH_FETCH;
         r_chan       <= CH_FETCH;
         r_write      <= 1'b0;
         r_err        <= f_access_err(1'b1, 1'b0, F3_WORD, if_addr[1:0]);
         r_funct3     <= F3_WORD;
         r_addr       <= if_addr;
      end else if (w_grant_d) begin
         r_last_grant <= CH_DATA;
         r_chan       <= CH_DATA;
         r_write      <= d_write;
         r_err        <= f_access_err(1'b0, d_write, d_funct3, d_addr[1:0]);
         r_funct3     <= d_funct3;
         r_addr       <= d_addr;
         r_wdata      <= d_wdata;
      end
   end

   assign mem_write_address = r_addr;
   assign mem_read_address  = r_addr;
   assign mem_write_data    = r_wdata;

   // Read data is only meaningful for a legal load or fetch.
   assign w_rsp_data = (r_err || r_write) ? 32'd0 : mem_read_data;

   // Output logic. Reset gates every strobe in the cycle it is asserted,
   // so a request caught in ISSUE never writes and one in RESP never
   // responds. funct3 is held through RESP because memory decodes the
   // read path combinationally from the current read address and funct3.
   always_comb begin
      mem_write    = 1'b0;
      mem_funct3   = F3_WORD;
      if_rsp_valid = 1'b0;
      if_rsp_data  = 32'd0;
      if_rsp_err   = 1'b0;
      d_rsp_valid  = 1'b0;
      d_rsp_rdata  = 32'd0;
      d_rsp_err    = 1'b0;
      if (!reset) begin
         case (r_state)
            S_ISSUE: begin
               mem_funct3 = r_funct3;
               mem_write  = r_write && !r_err;
            end
            S_RESP: begin
               mem_funct3 = r_funct3;
               if (r_chan == CH_FETCH) begin
                  if_rsp_valid = 1'b1;
                  if_rsp_data  = w_rsp_data;
                  if_rsp_err   = r_err;
               end else begin
                  d_rsp_valid  = 1'b1;
                  d_rsp_rdata  = w_rsp_data;
                  d_rsp_err    = r_err;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-side initiator for the RV32I core: accepts instruction-fetch and load/store requests from the core, arbitrates between them, and drives the single-ported `memory` block (one write port, one registered read port, shared `funct3`). It checks alignment and `funct3` legality before issuing an access. It returns the read data, or an error, on a per-channel response strobe. The block sits between the core datapath and `memory`, and is the only driver of `memory`'s inputs.

## Interface
- No parameters.
- `clk` in 1: system clock (12 MHz).
- `reset` in 1: synchronous, active-high.
- `if_valid` in 1: fetch request valid.
- `if_ready` out 1: fetch request accepted when `if_valid & if_ready`.
- `if_addr` in 32: fetch byte address.
- `if_rsp_valid` out 1: one-cycle fetch response strobe.
- `if_rsp_data` out 32: fetched instruction.
- `if_rsp_err` out 1: fetch misaligned.
- `d_valid` in 1: data request valid.
- `d_ready` out 1: data request accepted when `d_valid & d_ready`.
- `d_write` in 1: 1 = store, 0 = load.
- `d_funct3` in 3: RV32I load/store `funct3`.
- `d_addr` in 32: data byte address.
- `d_wdata` in 32: store data, right-aligned.
- `d_rsp_valid` out 1: one-cycle data response strobe.
- `d_rsp_rdata` out 32: load result (already extended by memory).
- `d_rsp_err` out 1: misaligned or illegal `funct3`.
- `mem_write` out 1: write strobe to memory.
- `mem_funct3` out 3: access size/sign to memory.
- `mem_write_address` out 32: memory write address.
- `mem_write_data` out 32: memory write data.
- `mem_read_address` out 32: memory read address.
- `mem_read_data` in 32: memory read data, valid the cycle after the address edge.

## Operation
- FSM states: IDLE, ISSUE, RESP. Reset state is IDLE.
- IDLE -> ISSUE on a handshake on either channel. ISSUE -> RESP always. RESP -> IDLE always. Only one request is outstanding at a time.
- `if_ready` and `d_ready` are driven only in IDLE, and are 0 in the cycle `reset` is high.
- Single valid request: grant that channel.
- Both valid: grant the channel not granted last. `last_grant` resets to FETCH, so data wins the first tie.
- The non-granted channel's ready is 0 in the handshake cycle.
- On grant, latch the request fields: fetch forces write=0 and funct3=3'b010.

Error check, evaluated at latch:
- Fetch: `addr[1:0] != 0`.
- Load: funct3 ∈ {011, 110, 111}; word access with `addr[1:0] != 0`; half access with `addr[0] != 0`.
- Store: funct3 ∉ {000, 001, 010}; same alignment rules as load.

ISSUE state:
- Drive `mem_funct3` = latched funct3, `mem_read_address` = latched address, `mem_write_address` = latched address, `mem_write_data` = latched `wdata` (unshifted; memory performs lane placement).
- `mem_write` = 1 only for a non-error store.
- Error requests issue no write. The read address is still driven but its data is discarded.

RESP state:
- `mem_write` = 0. `mem_read_address` and `mem_funct3` are held unchanged, because memory selects the array or the peripheral path combinationally from the current read address.
- Assert the granted channel's `rsp_valid` for exactly one cycle.
- `rsp_data` = `mem_read_data` for a non-error load or fetch, else 0.
- `rsp_err` = latched error flag.
- Stores return `rdata` = 0.

Outside ISSUE/RESP:
- `mem_write` = 0, `mem_funct3` = 3'b010.
- Addresses and write data hold their last value.

## Timing
- Handshake at edge E0. ISSUE is the cycle after E0, and the memory captures the access at edge E1. RESP is the cycle after E1. The unit returns to IDLE after E2.
- Response latency: `rsp_valid` is high in the second cycle after the handshake cycle.
- Throughput: one request per 3 cycles.
- Store data is committed to memory at E1 and is visible to a load issued after the store's RESP.
- Reset values: all outputs 0 except `mem_funct3` = 3'b010. The FSM is in IDLE and `last_grant` = FETCH.
- Reset in ISSUE:
  - `mem_write` is forced to 0 that cycle, so no write occurs.
  - No response is generated and the request is dropped.
- Reset in RESP: the response strobe is suppressed.
- A request whose valid drops before its handshake is ignored; the channel has no obligation to hold valid.
- Address wrap: 0xFFFFFFFC with funct3 = 010 is a legal aligned access to the peripheral region and is passed through unchanged.

## Test plan
- Fetch `if_addr` = 0x00000004 with preloaded word 0x00500093 -> `if_rsp_valid` high 2 cycles after the handshake, data 0x00500093, err 0, `mem_write` never 1.
- Store word 0xDEADBEEF to 0x100, then load byte signed (funct3 000) from 0x103 -> load returns 0xFFFFFFDE with err 0. Load byte unsigned (funct3 100) from 0x103 -> 0x000000DE.
- Simultaneous `if_valid` and `d_valid` held for 4 requests -> grants alternate D, F, D, F, and each ready pulses only in IDLE.
- Load half (funct3 001) from 0x101, and store with funct3 = 100 -> `d_rsp_err` = 1, rdata 0, `mem_write` stays 0, and memory contents are unchanged.
- Store 0x00FF0080 to 0xFFFFFFFC -> LED PWM duty values updated. Load word from 0xFFFFFFFC -> 0x00FF0080.
- Assert `reset` during ISSUE of a store to 0x200 -> no write to 0x200, no `d_rsp_valid`, all outputs at reset values, and the next request is served normally.
